// File: rtl/lsu.sv
// Load/store unit: splits RV32 loads and stores into data-memory beats.
// Aligned words go out as a single word beat; halves, bytes and unaligned words
// go out as byte beats. Out-of-range or illegal accesses fault with no beats.
module lsu (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic        rsp_split,
   output logic        MemWrite,
   output logic        MemRead,
   output logic [2:0]  DMType,
   output logic [31:0] Address,
   output logic [31:0] Write_data,
   input  logic [31:0] Read_data
);

   typedef enum logic [1:0] {Idle, Access, Resp} state_t;

   state_t      state_q;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] acc_q;
   logic [1:0]  beat_q;
   logic [1:0]  last_q;
   logic        word_q;
   logic        fault_q;

   logic        legal;
   logic [32:0] size;
   logic [32:0] end_addr;
   logic        bad;
   logic        word_d;
   logic [1:0]  last_d;

   // Decode the incoming request: legality, range check and beat plan.
   always_comb begin
      legal = 1'b0;
      size  = 33'd1;
      case (req_funct3)
         3'b000:  begin legal = 1'b1;     size = 33'd1; end
         3'b001:  begin legal = 1'b1;     size = 33'd2; end
         3'b010:  begin legal = 1'b1;     size = 33'd4; end
         3'b100:  begin legal = !req_we;  size = 33'd1; end
         3'b101:  begin legal = !req_we;  size = 33'd2; end
         default: begin legal = 1'b0;     size = 33'd1; end
      endcase
      // 33-bit sum so a wrap past 0xFFFFFFFF still lands above the limit
      end_addr = {1'b0, req_addr} + size - 33'd1;
      bad      = !legal || (end_addr > 33'h0_0000_7FFF);
      word_d   = (req_funct3 == 3'b010) && (req_addr[1:0] == 2'b00);
      if (req_funct3[1:0] == 2'b01) begin
         last_d = 2'd1;
      end else if ((req_funct3 == 3'b010) && !word_d) begin
         last_d = 2'd3;
      end else begin
         last_d = 2'd0;
      end
   end

   // Control FSM, latched request and load accumulator.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= Idle;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         acc_q    <= 32'h0;
         beat_q   <= 2'd0;
         last_q   <= 2'd0;
         word_q   <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         case (state_q)
            Idle: begin
               if (req_valid) begin
                  we_q     <= req_we;
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  acc_q    <= 32'h0;
                  beat_q   <= 2'd0;
                  if (bad) begin
                     fault_q <= 1'b1;
                     word_q  <= 1'b0;
                     last_q  <= 2'd0;
                     state_q <= Resp;
                  end else begin
                     fault_q <= 1'b0;
                     word_q  <= word_d;
                     last_q  <= last_d;
                     state_q <= Access;
                  end
               end
            end
            Access: begin
               if (!we_q) begin
                  if (word_q) begin
                     acc_q <= Read_data;
                  end else begin
                     acc_q[{beat_q, 3'b000} +: 8] <= Read_data[7:0];
                  end
               end
               if (beat_q == last_q) begin
                  state_q <= Resp;
               end else begin
                  beat_q <= beat_q + 2'd1;
               end
            end
            Resp: begin
               if (rsp_ready) begin
                  state_q <= Idle;
               end
            end
            default: state_q <= Idle;
         endcase
      end
   end

   // Memory command for the current beat; quiet outside ACCESS.
   always_comb begin
      MemWrite   = 1'b0;
      MemRead    = 1'b0;
      DMType     = 3'b000;
      Address    = 32'h0;
      Write_data = 32'h0;
      if (state_q == Access) begin
         MemWrite = we_q;
         MemRead  = !we_q;
         Address  = addr_q + {30'h0, beat_q};
         if (word_q) begin
            DMType     = 3'b010;
            Write_data = wdata_q;
         end else begin
            DMType     = we_q ? 3'b000 : 3'b100;
            Write_data = {24'h0, wdata_q[{beat_q, 3'b000} +: 8]};
         end
      end
   end

   // Handshake flags and extended load result.
   always_comb begin
      req_ready = (state_q == Idle);
      rsp_valid = (state_q == Resp);
      rsp_fault = rsp_valid && fault_q;
      rsp_split = rsp_valid && !fault_q && !word_q;
      rsp_rdata = 32'h0;
      if (rsp_valid && !fault_q && !we_q) begin
         case (funct3_q)
            3'b000:  rsp_rdata = {{24{acc_q[7]}}, acc_q[7:0]};
            3'b001:  rsp_rdata = {{16{acc_q[15]}}, acc_q[15:0]};
            3'b010:  rsp_rdata = acc_q;
            3'b100:  rsp_rdata = {24'h0, acc_q[7:0]};
            3'b101:  rsp_rdata = {16'h0, acc_q[15:0]};
            default: rsp_rdata = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: byte-addressed data memory, directed cases and random traffic
// checked against a byte-level reference model of the load/store rules.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_fault, rsp_split;
   logic [31:0] rsp_rdata;
   logic        MemWrite, MemRead;
   logic [2:0]  DMType;
   logic [31:0] Address, Write_data, Read_data;

   int checks = 0;
   int errors = 0;

   logic [7:0] env_mem [0:32767];
   logic [7:0] ref_mem [0:32767];
   logic       mem_fill;

   always #5 clk = ~clk;

   lsu dut (
      .clk        (clk),
      .rstn       (rstn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_fault  (rsp_fault),
      .rsp_split  (rsp_split),
      .MemWrite   (MemWrite),
      .MemRead    (MemRead),
      .DMType     (DMType),
      .Address    (Address),
      .Write_data (Write_data),
      .Read_data  (Read_data)
   );

   function automatic logic [7:0] pat(input int i);
      return 8'((i * 37 + 11) & 255);
   endfunction

   // Data memory: combinational read, write on the rising edge.
   always_comb begin
      logic [14:0] a;
      a = Address[14:0];
      if (DMType == 3'b010)
         Read_data = {env_mem[a + 15'd3], env_mem[a + 15'd2], env_mem[a + 15'd1], env_mem[a]};
      else
         Read_data = {24'h0, env_mem[a]};
   end

   always @(posedge clk) begin
      if (mem_fill) begin
         for (int i = 0; i < 32768; i++) env_mem[i] <= pat(i);
      end else if (MemWrite) begin
         if (DMType == 3'b010) begin
            for (int j = 0; j < 4; j++)
               env_mem[Address[14:0] + 15'(j)] <= Write_data[8*j +: 8];
         end else begin
            env_mem[Address[14:0]] <= Write_data[7:0];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One transaction; entered and left #1 after a rising edge with the DUT idle.
   task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input int stall);
      int          size, n, lat, seen;
      logic        legal, efault, eword, esplit;
      logic [32:0] last_byte;
      logic [31:0] v, erdata, hold_rdata;
      logic [2:0]  edm;

      // Reference model from the access rules
      case (f3)
         3'b000: begin legal = 1'b1; size = 1; end
         3'b001: begin legal = 1'b1; size = 2; end
         3'b010: begin legal = 1'b1; size = 4; end
         3'b100: begin legal = !we;  size = 1; end
         3'b101: begin legal = !we;  size = 2; end
         default: begin legal = 1'b0; size = 1; end
      endcase
      last_byte = {1'b0, a} + 33'(size) - 33'd1;
      efault = !legal || (last_byte > 33'h7FFF);
      eword  = !efault && (f3 == 3'b010) && (a % 4 == 0);
      n      = efault ? 0 : (eword ? 1 : size);
      esplit = !efault && !eword;
      v = 32'h0;
      if (!efault)
         for (int k = 0; k < size; k++) v[8*k +: 8] = ref_mem[a + 32'(k)];
      erdata = 32'h0;
      if (!efault && !we) begin
         case (f3)
            3'b000: erdata = v[7] ? (v | 32'hFFFF_FF00) : v;
            3'b001: erdata = v[15] ? (v | 32'hFFFF_0000) : v;
            3'b100, 3'b101, 3'b010: erdata = v;
            default: erdata = 32'h0;
         endcase
      end
      edm = eword ? 3'b010 : (we ? 3'b000 : 3'b100);

      check("req_ready_idle", {31'h0, req_ready}, 32'h1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat  = 1;
      seen = 0;
      while (!rsp_valid && lat <= 8) begin
         if (MemRead || MemWrite) begin
            check("beat_addr", Address, a + 32'(seen));
            check("beat_dmtype", {29'h0, DMType}, {29'h0, edm});
            check("beat_we", {30'h0, MemWrite, MemRead}, {30'h0, we, !we});
            if (we) begin
               if (eword) check("beat_wdata", Write_data, wd);
               else       check("beat_wbyte", {24'h0, Write_data[7:0]}, {24'h0, wd[8*seen +: 8]});
            end
            seen++;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      check("rsp_valid", {31'h0, rsp_valid}, 32'h1);
      check("latency", 32'(lat), 32'(n + 1));
      check("beats", 32'(seen), 32'(n));
      check("rsp_fault", {31'h0, rsp_fault}, {31'h0, efault});
      check("rsp_split", {31'h0, rsp_split}, {31'h0, esplit});
      check("rsp_rdata", rsp_rdata, erdata);
      check("bus_quiet_resp", {MemWrite, MemRead, DMType, Address[26:0]}, 32'h0);
      check("bus_wdata_resp", Write_data, 32'h0);
      hold_rdata = rsp_rdata;
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         #1;
         check("stall_valid", {30'h0, rsp_valid, req_ready}, 32'h2);
         check("stall_rdata", rsp_rdata, hold_rdata);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      check("after_handshake", {30'h0, rsp_valid, req_ready}, 32'h1);
      if (we && !efault)
         for (int k = 0; k < size; k++) ref_mem[a + 32'(k)] = wd[8*k +: 8];
   endtask

   initial begin
      logic       rwe;
      logic [2:0] rf3;
      logic [31:0] raddr;
      int          r;

      rstn       = 1'b0;
      mem_fill   = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      rsp_ready  = 1'b0;
      for (int i = 0; i < 32768; i++) ref_mem[i] = pat(i);
      repeat (2) @(posedge clk);
      #1;
      check("reset_ready", {31'h0, req_ready}, 32'h1);
      check("reset_outs", {rsp_valid, rsp_fault, rsp_split, MemWrite, MemRead, DMType, Address[24:0]},
            32'h0);
      check("reset_rdata", rsp_rdata, 32'h0);
      mem_fill = 1'b0;
      rstn     = 1'b1;
      @(posedge clk);
      #1;

      // Aligned word store then load
      op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0);
      op(1'b0, 3'b010, 32'h100, 32'h0, 0);
      // Unaligned word store / load
      op(1'b1, 3'b010, 32'h203, 32'h11223344, 0);
      op(1'b0, 3'b010, 32'h203, 32'h0, 0);
      // Sign / zero extension
      op(1'b1, 3'b001, 32'h10, 32'h0000FF80, 0);
      op(1'b0, 3'b001, 32'h10, 32'h0, 0);
      op(1'b0, 3'b101, 32'h10, 32'h0, 0);
      op(1'b0, 3'b000, 32'h10, 32'h0, 0);
      op(1'b0, 3'b100, 32'h11, 32'h0, 0);
      // Faults and range boundary
      op(1'b0, 3'b010, 32'h7FFE, 32'h0, 0);
      op(1'b0, 3'b011, 32'h40, 32'h0, 0);
      op(1'b1, 3'b100, 32'h40, 32'h55, 0);
      op(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 0);
      op(1'b0, 3'b010, 32'h7FFC, 32'h0, 0);
      op(1'b1, 3'b000, 32'h7FFF, 32'hA5, 0);
      // Response back-pressure
      op(1'b0, 3'b010, 32'h100, 32'h0, 3);

      // Reset in beat 1 of an unaligned word store
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h301;
      req_wdata  = 32'hA1B2C3D4;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("abort_beat0", Address, 32'h301);
      @(posedge clk);
      #1;
      check("abort_beat1", Address, 32'h302);
      rstn = 1'b0;
      #1;
      check("abort_outs", {MemWrite, MemRead, rsp_valid, DMType, Address[25:0]}, 32'h0);
      check("abort_ready", {31'h0, req_ready}, 32'h1);
      #2;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check("abort_byte0", {24'h0, env_mem[15'h301]}, 32'h000000D4);
      check("abort_byte1", {24'h0, env_mem[15'h302]}, {24'h0, ref_mem[32'h302]});
      ref_mem[32'h301] = 8'hD4;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("abort_no_rsp", {30'h0, rsp_valid, req_ready}, 32'h1);
      end
      op(1'b0, 3'b010, 32'h300, 32'h0, 0);

      // Random traffic
      for (int t = 0; t < 80; t++) begin
         r   = int'($urandom_range(0, 9));
         rwe = 1'($urandom_range(0, 1));
         rf3 = 3'($urandom_range(0, 7));
         if (r == 0)      raddr = $urandom;
         else if (r == 1) raddr = 32'h7FF8 + $urandom_range(0, 7);
         else             raddr = $urandom_range(0, 32'h3F);
         op(rwe, rf3, raddr, $urandom, int'($urandom_range(0, 2)));
      end
      for (int k = 0; k < 64; k += 4) op(1'b0, 3'b010, 32'(k), 32'h0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 The block SHALL have ports `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port `rstn`, input, 1 bit: reset, asynchronous and active-low.
REQ-003 The block SHALL have ports `req_valid` (input, 1) and `req_ready` (output, 1): request handshake from the MEM pipeline stage.
REQ-004 The block SHALL have ports `req_we` (input, 1), `req_funct3` (input, 3), `req_addr` (input, 32) and `req_wdata` (input, 32): store flag, RV32 load/store funct3, byte address, store data.
REQ-005 The block SHALL have ports `rsp_valid` (output, 1) and `rsp_ready` (input, 1): response handshake toward writeback.
REQ-006 The block SHALL have ports `rsp_rdata` (output, 32), `rsp_fault` (output, 1) and `rsp_split` (output, 1): extended load result, access fault, and "access used byte beats" flag.
REQ-007 The block SHALL have ports `MemWrite`, `MemRead` (outputs, 1 each), `DMType` (output, 3), `Address` and `Write_data` (outputs, 32 each): data-memory command.
REQ-008 The block SHALL have port `Read_data`, input, 32 bits: combinational read data from the data memory.

Function
REQ-009 The block SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-010 `req_ready` SHALL be 1 only in IDLE; a request is accepted when `req_valid` && `req_ready` are both high at a rising edge, which latches all request fields.
REQ-011 Legal funct3 values SHALL be 000 (B), 001 (H), 010 (W), 100 (BU, loads only) and 101 (HU, loads only); sizes are 1, 2 and 4 bytes.
REQ-012 On acceptance, a fault SHALL be raised and the FSM SHALL go directly to RESP with no memory beats if funct3 is illegal, or if `req_addr` + size - 1, computed in 33 bits, exceeds 0x7FFF (wrap-around past 0xFFFFFFFF is included).
REQ-013 Otherwise the FSM SHALL enter ACCESS with beat count N: N=1 for a word with `addr[1:0]`==0 or for a byte; N=2 for a half; N=4 for a word with `addr[1:0]`!=0.
REQ-014 An aligned word SHALL be issued as one beat with `DMType`=010; every other beat SHALL be a byte beat with `DMType`=100 for loads and 000 for stores.
REQ-015 Beat k (0..N-1) SHALL occupy exactly one cycle with `Address`=`req_addr`+k; for stores `Write_data[7:0]`=`wdata[8k+7:8k]` (byte beat) or the full `wdata` (word beat), with `MemWrite`=1.
REQ-016 For loads, beat k SHALL drive `MemRead`=1 and capture `Read_data[7:0]` into accumulator byte k (or all 32 bits for a word beat) at the rising edge ending the beat.
REQ-017 After the last beat the FSM SHALL go to RESP.
REQ-018 In RESP, `rsp_valid`=1 SHALL be held with all response fields stable until `rsp_ready`=1, then the FSM returns to IDLE; there is no IDLE bypass, so the earliest next accept is the following cycle.
REQ-019 `rsp_rdata` SHALL be the accumulator sign-extended for B/H and zero-extended for BU/HU; it SHALL be 0 for stores and faults.
REQ-020 `rsp_split` SHALL be 1 when N>1, or N=1 with a byte beat; it SHALL be 0 for aligned words and faults.
REQ-021 Outside ACCESS, `MemWrite`, `MemRead`, `DMType`, `Address` and `Write_data` SHALL all be 0.
REQ-022 Latency from accept edge T to `rsp_valid` SHALL be N+1 cycles for an access (rising at T+N+1) and 1 cycle for a fault (rising at T+1).

Reset
REQ-023 `rstn`=0 SHALL immediately force IDLE, with beat counter, accumulator and latched request cleared, and all outputs 0 except `req_ready`, which is 1 once in IDLE.
REQ-024 A reset during ACCESS SHALL abort the access, with bytes already written left in memory (no rollback) and no response issued.

Verification
REQ-025 Aligned LW at 0x100, memory word 0xDEADBEEF -> one beat with `DMType` 010; `rsp_rdata`=0xDEADBEEF, `rsp_split`=0, `rsp_valid` at T+2.
REQ-026 SW 0x11223344 at 0x203 -> four beats at addresses 0x203..0x206 writing 44, 33, 22, 11; `rsp_split`=1, `rsp_valid` at T+5; a following LW at 0x203 returns 0x11223344.
REQ-027 LH at 0x10 holding bytes 0x80,0xFF -> `rsp_rdata`=0xFFFFFF80; LHU at the same address -> 0x0000FF80; LB of byte 0x80 -> 0xFFFFFF80.
REQ-028 LW at 0x7FFE, funct3 011, SB with funct3 100 and address 0xFFFFFFFF with LH -> `rsp_fault`=1, `rsp_rdata`=0, no `MemRead`/`MemWrite` pulses, `rsp_valid` at T+1.
REQ-029 `rsp_ready` held low for 3 cycles in RESP -> `rsp_valid` and data stay stable and `req_ready` stays 0; accept resumes the cycle after the handshake.
REQ-030 `rstn` pulsed low during beat 1 of an unaligned SW -> outputs 0 asynchronously, byte 0 retained in memory, no `rsp_valid`, `req_ready`=1 after release.
